shift_register_n: RTL
=====================

// Module: shift_register_n
// PURPOSE
//  Parametrised multi-mode register: parallel load, clear, and multi-step shift/rotate on a WIDTH-bit state.
//  Multi-cycle shift operations are driven by a start/busy/done handshake.
//  Next-generation storage element for the datapath labs. Sits between the ALU result bus and downstream consumers of q/sout.
// PARAMETERS
//  WIDTH      8    register width in bits, >=2
//  RESET_VAL  0    value loaded into q on reset, WIDTH bits
//  AW         $clog2(WIDTH)+1   width of amt (localparam, derived)
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      begin operation; sampled only in IDLE
//  mode    in   3      operation code, sampled with start
//  amt     in   AW     step count for shift/rotate ops, sampled with start
//  d       in   WIDTH  parallel load data, sampled with start
//  sin     in   1      serial input, sampled on every RUN edge
//  q       out  WIDTH  register contents
//  sout    out  1      last bit shifted/rotated out
//  busy    out  1      high while in RUN
//  done    out  1      one-cycle completion pulse
//  parity  out  1      only with SHREG_PARITY_EN
// BEHAVIOUR
//  - Reset (async, any state): q=RESET_VAL, sout=0, busy=0, done=0, FSM=IDLE, step counter=0, latched mode=0.
//  - Mode codes:
//    - 000 HOLD
//    - 001 LOAD q<=d
//    - 010 SHL {q[W-2:0],sin}
//    - 011 SHR {sin,q[W-1:1]}
//    - 100 ROL
//    - 101 ROR
//    - 110 ASR {q[W-1],q[W-1:1]}
//    - 111 CLEAR q<=0
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE, start=0: no change.
//  - IDLE, start=1, mode in {HOLD,LOAD,CLEAR}:
//    - Apply the op on this edge; sout unchanged.
//    - Go to DONE.
//  - IDLE, start=1, shift/rotate mode, amt=0: q unchanged; go to DONE.
//  - IDLE, start=1, shift/rotate mode, amt>0:
//    - Latch mode; cnt<=min(amt,WIDTH) (amt>WIDTH saturates to WIDTH).
//    - Go to RUN.
//  - RUN:
//    - Each edge performs exactly one step of the latched mode and decrements cnt.
//    - sout <= the bit leaving q: MSB for SHL/ROL, LSB for SHR/ROR/ASR.
//    - The step that takes cnt 1->0 also moves the FSM to DONE.
//  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//  - Latency:
//    - Single-cycle ops: done in the cycle after the start edge.
//    - Shift ops with n=min(amt,WIDTH): busy for n cycles; done in cycle n+1 after the start edge.
//  - start while in RUN or DONE: ignored, not queued. mode/amt/d changes during RUN have no effect.
//  - Rotate by WIDTH returns the original q; sout = last bit rotated.
//  - busy and done are never high together. All outputs are registered.
// CONFIGURATION
//  - SHREG_PARITY_EN defined: the parity port exists.
//    - parity = XOR of all bits of q, registered on the same edges as q.
//    - Reset value = ^RESET_VAL.
//  - SHREG_PARITY_EN undefined: the parity port and its logic are absent. All other behaviour is identical.
// TESTING (WIDTH=8, RESET_VAL=0)
//  1. rst=1 mid-clock-period -> q=8'h00, sout=0, busy=0, done=0 immediately, before any clk edge.
//  2. start, mode=LOAD, d=8'hA5 -> q=8'hA5 after the edge; done=1 for one cycle; busy never high.
//  3. From q=8'hA5: start, mode=SHL, amt=3, sin=1
//     -> busy 3 cycles; q=8'h4B, 8'h97, 8'h2F; sout=1; done in cycle 4.
//  4. From q=8'h2F: ROR amt=8 -> q=8'h2F after 8 busy cycles.
//     Then ROR amt=12 -> saturates; 8 busy cycles; q=8'h2F.
//  5. Load 8'h90: ASR amt=2 -> q=8'hE4, sout=0.
//     Then SHL amt=0 -> done next cycle, q unchanged, busy never high.
//  6. Robustness, from q=8'h2F:
//     - SHR amt=5; pulse start again during RUN -> second start ignored (busy stays high exactly 5 cycles).
//     - Rerun the op and assert rst after 2 RUN cycles -> q=8'h00, busy=0, FSM idle; next LOAD works.
//     - With SHREG_PARITY_EN: parity tracks ^q throughout.

Source files
------------

// File: rtl/shift_register_n.sv
// shift_register_n: multi-mode WIDTH-bit register with load/clear and start/busy/done multi-step shift/rotate.
// Optional parity output enabled by defining SHREG_PARITY_EN.
module shift_register_n #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int AW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef SHREG_PARITY_EN
  ,
  output logic             parity
`endif
);
  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [2:0] lmode;
  logic [AW-1:0] cnt;
  logic [WIDTH-1:0] sh_q, q_nxt;
  logic sh_out, single;
  always_comb begin
    sh_q   = lmode == M_SHL ? {q[WIDTH-2:0], sin} :
             lmode == M_SHR ? {sin, q[WIDTH-1:1]} :
             lmode == M_ROL ? {q[WIDTH-2:0], q[WIDTH-1]} :
             lmode == M_ROR ? {q[0], q[WIDTH-1:1]} :
                              {q[WIDTH-1], q[WIDTH-1:1]};
    sh_out = (lmode == M_SHL || lmode == M_ROL) ? q[WIDTH-1] : q[0];
    single = mode == M_HOLD || mode == M_LOAD || mode == M_CLR;
    q_nxt  = state == RUN ? sh_q :
             (state == IDLE && start && mode == M_LOAD) ? d :
             (state == IDLE && start && mode == M_CLR) ? '0 : q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= RESET_VAL;
      sout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      lmode <= '0;
    end else begin
      q <= q_nxt;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (single || amt == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              lmode <= mode;
              cnt   <= amt > AW'(WIDTH) ? AW'(WIDTH) : amt;
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          sout <= sh_out;
          cnt  <= cnt - 1'b1;
          if (cnt == AW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
`ifdef SHREG_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    parity <= rst ? ^RESET_VAL : ^q_nxt;
`endif
endmodule
